mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory responder for the 8-bit CPU bus, plus a program-load port. It serves the CPU's read and write strobes from an internal RAM of 2^ADDR_WIDTH words. A byte-stream loader, using a valid/ready handshake, can fill the RAM sequentially from address 0 while the CPU is held in reset. It sits between the CPU's memory interface and the board-level programmer (UART bridge or switch panel) and replaces the manual programming mode.

## Interface
- DATA_WIDTH, 8, word width of RAM and bus
- ADDR_WIDTH, 4, address width; RAM depth 2^ADDR_WIDTH
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_clke  in  1  CPU clock enable; qualifies CPU-side writes and the release handshake
- i_re  in  1  CPU read strobe
- i_we  in  1  CPU write strobe
- i_addr  in  ADDR_WIDTH  CPU address
- i_data  in  DATA_WIDTH  CPU write data
- o_data  out  DATA_WIDTH  read data to CPU
- i_ld_start  in  1  request to begin a program load
- i_ld_valid  in  1  loader byte valid
- i_ld_data  in  DATA_WIDTH  loader byte
- i_ld_last  in  1  marks final byte of the stream
- o_ld_ready  out  1  loader byte accepted when valid & ready at the clock edge
- o_ld_addr  out  ADDR_WIDTH  next load address
- o_ld_err  out  1  sticky overflow flag
- o_cpu_reset  out  1  hold the CPU in reset; OR it into the CPU's i_reset
- o_busy  out  1  high in any state other than RUN

## Operation
- States: RUN, CLEAR (only with MEM_CLEAR_EN), LOAD, RELEASE.
- RUN:
  - o_data = mem[i_addr] when i_re, else 0. Reads are combinational; there is no read latency.
  - Write mem[i_addr] <= i_data at the edge where i_clke & i_we.
  - i_ld_start goes to CLEAR (or to LOAD when the macro is absent). It also sets load address = 0 and clears o_ld_err.
- LOAD:
  - o_ld_ready = 1.
  - On each handshake: mem[ld_addr] <= i_ld_data, then ld_addr increments.
  - A handshake with i_ld_last goes to RELEASE.
  - A handshake at ld_addr = 2^ADDR_WIDTH-1 without i_ld_last sets o_ld_err, wraps ld_addr to 0, and goes to RELEASE. Further bytes are not accepted.
  - CPU strobes are ignored and o_data = 0.
  - i_ld_start is ignored.
- RELEASE:
  - o_cpu_reset stays high.
  - The block exits to RUN at the first edge with i_clke = 1, so the CPU samples reset under its enable at least once.
- o_cpu_reset = 1 in CLEAR, LOAD and RELEASE; 0 in RUN.
- o_ld_addr reflects ld_addr in all states.
- Simultaneous events:
  - i_ld_start together with a CPU write in RUN: the write completes and the state changes at the same edge.
- Reset values:
  - state = RUN
  - ld_addr = 0
  - o_ld_err = 0
  - o_ld_ready = 0
  - o_cpu_reset = 0
  - o_busy = 0
- RAM contents are not reset.
- Reset mid-load returns to RUN immediately; bytes already written are kept.

## Timing
- Loader throughput is one byte per i_clk, independent of i_clke.
- A byte handshaked at edge N is readable by the CPU once the block returns to RUN.
- The last-byte handshake at edge N makes RELEASE visible after edge N.
- o_cpu_reset falls after the first i_clke = 1 edge that follows.
- o_ld_ready is registered-state-driven, with no combinational path from i_ld_valid.

## Configuration
- MEM_CLEAR_EN defined:
  - i_ld_start enters CLEAR, which writes 0 to one word per i_clk from address 0 to 2^ADDR_WIDTH-1. This takes 2^ADDR_WIDTH cycles.
  - The block then enters LOAD with ld_addr = 0.
  - o_ld_ready = 0 throughout CLEAR.
  - Unloaded words therefore read 0.
- MEM_CLEAR_EN undefined:
  - CLEAR does not exist; i_ld_start goes directly to LOAD.
  - Words not written by the stream keep their previous contents.

## Test plan
- Load 3 bytes 0x1E, 0x2F, 0xF0 (last on the third), with i_clke toggling every 4 cycles.
  - Required: o_cpu_reset holds until the first i_clke after the third handshake.
  - Required: a CPU read of addresses 0, 1 and 2 returns 0x1E, 0x2F and 0xF0.
- Stream 17 bytes without last, at ADDR_WIDTH=4.
  - Required: the 16th handshake sets o_ld_err = 1 and enters RELEASE.
  - Required: the 17th byte is never accepted (o_ld_ready = 0).
  - Required: o_ld_addr = 0.
- In RUN, write 0x55 to address 7 with i_we & i_clke, then read it.
  - Required: o_data = 0x55 in the same cycle i_re rises.
  - Required: with i_we high but i_clke low, no write occurs.
- Assert i_reset after 2 bytes of a 5-byte load.
  - Required: the next cycle is RUN, with o_cpu_reset = 0 and o_ld_ready = 0.
  - Required: addresses 0 and 1 hold the new bytes and address 2 keeps its old value.
- With MEM_CLEAR_EN, preload address 9 = 0xAA, then load 2 bytes.
  - Required: o_ld_ready stays low for 16 cycles after i_ld_start.
  - Required: address 9 reads 0x00.
  - Without the macro, address 9 reads 0xAA.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: CPU memory bus plus program-load stream for mem_ctrl.
//
// CPU side:    i_clke, i_re, i_we, i_addr, i_data -> o_data (combinational read)
// Loader side: i_ld_start, i_ld_valid, i_ld_data, i_ld_last -> o_ld_ready,
//              o_ld_addr, o_ld_err
//
// Handshake: a loader byte transfers at a rising i_clk edge where
// i_ld_valid & o_ld_ready are both high. o_ld_ready comes from registered
// state only and never depends on i_ld_valid; the source may hold
// i_ld_valid high across cycles and only advances data after a transfer.
//
// Modports: slave = mem_ctrl, master = the CPU / programmer side.
interface mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) ();
  logic                  i_clke;
  logic                  i_re;
  logic                  i_we;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ld_start;
  logic                  i_ld_valid;
  logic [DATA_WIDTH-1:0] i_ld_data;
  logic                  i_ld_last;
  logic                  o_ld_ready;
  logic [ADDR_WIDTH-1:0] o_ld_addr;
  logic                  o_ld_err;

  modport slave (
    input  i_clke, i_re, i_we, i_addr, i_data,
    input  i_ld_start, i_ld_valid, i_ld_data, i_ld_last,
    output o_data, o_ld_ready, o_ld_addr, o_ld_err
  );

  modport master (
    output i_clke, i_re, i_we, i_addr, i_data,
    output i_ld_start, i_ld_valid, i_ld_data, i_ld_last,
    input  o_data, o_ld_ready, o_ld_addr, o_ld_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: RAM responder for the 8-bit CPU bus with a sequential program
// loader that fills the RAM from address 0 while holding the CPU in reset.
//
// Ports:
//   i_clk       clock
//   i_reset     synchronous, active-high reset (RAM contents are kept)
//   bus         mem_ctrl_if.slave: CPU strobes/data and loader stream
//   o_cpu_reset high outside RUN; OR into the CPU's reset
//   o_busy      high outside RUN
//   o_state     current FSM state (RUN=0, CLEAR=1, LOAD=2, RELEASE=3)
//
// Optional feature macro: MEM_CLEAR_EN. When defined, a load request first
// zeroes the whole RAM (one word per clock) before accepting bytes.
module mem_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  mem_ctrl_if.slave   bus,
  output logic        o_cpu_reset,
  output logic        o_busy,
  output logic [1:0]  o_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
`ifdef MEM_CLEAR_EN
    S_CLEAR   = 2'd1,
`endif
    S_LOAD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_ready;
  logic                  ld_err;
  logic                  ld_fire;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign ld_fire = (state == S_LOAD) && ld_ready && bus.i_ld_valid;

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN: begin
        if (bus.i_ld_start) begin
`ifdef MEM_CLEAR_EN
          state_nx = S_CLEAR;
`else
          state_nx = S_LOAD;
`endif
        end
      end
`ifdef MEM_CLEAR_EN
      // ld_addr doubles as the clear pointer.
      S_CLEAR: if (ld_addr == LAST_ADDR) state_nx = S_LOAD;
`endif
      // Writing the top word without i_ld_last is an overflow: stop taking bytes.
      S_LOAD: if (ld_fire && (bus.i_ld_last || ld_addr == LAST_ADDR)) state_nx = S_RELEASE;
      // Wait for a CPU enable edge so the CPU samples its reset at least once.
      S_RELEASE: if (bus.i_clke) state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  // FSM, load pointer, error flag and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= S_RUN;
      ld_addr     <= '0;
      ld_err      <= 1'b0;
      ld_ready    <= 1'b0;
      o_cpu_reset <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_nx;
      ld_ready    <= (state_nx == S_LOAD);
      o_cpu_reset <= (state_nx != S_RUN);
      o_busy      <= (state_nx != S_RUN);
      case (state)
        S_RUN: begin
          if (bus.i_ld_start) begin
            ld_addr <= '0;
            ld_err  <= 1'b0;
          end
        end
`ifdef MEM_CLEAR_EN
        // Wraps back to 0 on the final clear write, ready for LOAD.
        S_CLEAR: ld_addr <= ld_addr + 1'b1;
`endif
        S_LOAD: begin
          if (ld_fire) begin
            ld_addr <= ld_addr + 1'b1;
            if (!bus.i_ld_last && ld_addr == LAST_ADDR) ld_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM write port; no reset on contents, but no writes during a reset edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      case (state)
        S_RUN: if (bus.i_clke && bus.i_we) mem[bus.i_addr] <= bus.i_data;
`ifdef MEM_CLEAR_EN
        S_CLEAR: mem[ld_addr] <= '0;
`endif
        S_LOAD: if (ld_fire) mem[ld_addr] <= bus.i_ld_data;
        default: ;
      endcase
    end
  end

  assign bus.o_data     = (state == S_RUN && bus.i_re) ? mem[bus.i_addr] : '0;
  assign bus.o_ld_ready = ld_ready;
  assign bus.o_ld_addr  = ld_addr;
  assign bus.o_ld_err   = ld_err;
  assign o_state        = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: self-checking bench for mem_ctrl. A reference RAM model is
// updated as writes/loads are driven; reads push the model value into a
// scoreboard queue and pop/compare when the DUT's read data is sampled.
module tb_mem_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       o_cpu_reset;
  logic       o_busy;
  logic [1:0] o_state;

  mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .bus         (bus.slave),
    .o_cpu_reset (o_cpu_reset),
    .o_busy      (o_busy),
    .o_state     (o_state)
  );

  // ---------------- clock / reset / clke ----------------
  always #5 i_clk = ~i_clk;

  logic       clke_auto = 1'b0;
  logic       clke_man  = 1'b0;
  logic [7:0] cyc       = 8'd0;
  always @(negedge i_clk) cyc <= cyc + 8'd1;
  // Auto mode toggles i_clke every 4 cycles; changes happen on negedges.
  assign bus.i_clke = clke_auto ? cyc[2] : clke_man;

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [16];
  logic [AW-1:0] exp_ld;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic en);
    bus.i_addr = a;
    bus.i_data = d;
    bus.i_we   = 1'b1;
    clke_man   = en;
    tick();
    bus.i_we   = 1'b0;
    clke_man   = 1'b0;
    if (en) model_mem[a] = d;
  endtask

  task automatic cpu_read(input string tag, input logic [AW-1:0] a, input logic in_run);
    logic [DW-1:0] e;
    exp_q.push_back(in_run ? model_mem[a] : '0);
    bus.i_addr = a;
    bus.i_re   = 1'b1;
    #1;
    e = exp_q.pop_front();
    check_val(tag, bus.o_data, e);
    bus.i_re = 1'b0;
  endtask

  task automatic start_load();
    bus.i_ld_start = 1'b1;
    tick();
    bus.i_ld_start = 1'b0;
    exp_ld = '0;
    check_val("start_err_clr", bus.o_ld_err, 0);
`ifdef MEM_CLEAR_EN
    for (int i = 0; i < 16; i++) begin
      check_val("clear_ready_low", bus.o_ld_ready, 0);
      tick();
    end
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
`endif
    check_val("load_ready", bus.o_ld_ready, 1);
    check_val("load_state", o_state, ST_LOAD);
    check_val("load_addr0", bus.o_ld_addr, 0);
    check_val("load_cpu_reset", o_cpu_reset, 1);
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    bus.i_ld_valid = 1'b1;
    bus.i_ld_data  = d;
    bus.i_ld_last  = last;
    for (int k = 0; k < 40 && !acc; k++) begin
      acc = bus.o_ld_ready;
      tick();
    end
    bus.i_ld_valid = 1'b0;
    bus.i_ld_last  = 1'b0;
    if (!acc) begin
      check_val("ld_timeout", 0, 1);
    end else begin
      model_mem[exp_ld] = d;
      exp_ld = exp_ld + 1'b1;
      check_val("ld_addr", bus.o_ld_addr, exp_ld);
    end
  endtask

  task automatic release_cpu();
    check_val("rel_state", o_state, ST_RELEASE);
    clke_man = 1'b0;
    tick();
    check_val("rel_hold_noclke", o_cpu_reset, 1);
    clke_man = 1'b1;
    tick();
    clke_man = 1'b0;
    check_val("rel_cpu_reset", o_cpu_reset, 0);
    check_val("rel_busy", o_busy, 0);
    check_val("rel_run", o_state, ST_RUN);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic c;
    logic rel_done;
    i_reset        = 1'b1;
    bus.i_re       = 1'b0;
    bus.i_we       = 1'b0;
    bus.i_addr     = '0;
    bus.i_data     = '0;
    bus.i_ld_start = 1'b0;
    bus.i_ld_valid = 1'b0;
    bus.i_ld_data  = '0;
    bus.i_ld_last  = 1'b0;
    exp_ld         = '0;
    repeat (3) tick();
    i_reset = 1'b0;

    // Reset values
    check_val("rst_state", o_state, ST_RUN);
    check_val("rst_ld_addr", bus.o_ld_addr, 0);
    check_val("rst_ld_err", bus.o_ld_err, 0);
    check_val("rst_ld_ready", bus.o_ld_ready, 0);
    check_val("rst_cpu_reset", o_cpu_reset, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_odata_idle", bus.o_data, 0);

    // Fill RAM with known random contents
    for (int i = 0; i < 16; i++) cpu_write(AW'(i), 8'($urandom_range(1, 255)), 1'b1);
    for (int i = 0; i < 16; i++) cpu_read("init_rd", AW'(i), 1'b1);

    // Test 1: 3-byte load with i_clke toggling every 4 cycles
    clke_auto = 1'b1;
    start_load();
    send_byte(8'h1E, 1'b0);
    cpu_read("load_rd_blocked", 4'd0, 1'b0);
    send_byte(8'h2F, 1'b0);
    send_byte(8'hF0, 1'b1);
    check_val("t1_release", o_state, ST_RELEASE);
    rel_done = 1'b0;
    for (int k = 0; k < 20 && !rel_done; k++) begin
      check_val("t1_hold", o_cpu_reset, 1);
      @(negedge i_clk);
      #1;
      c = bus.i_clke;
      tick();
      if (c) begin
        check_val("t1_drop", o_cpu_reset, 0);
        rel_done = 1'b1;
      end
    end
    if (!rel_done) check_val("t1_rel_timeout", 0, 1);
    clke_auto = 1'b0;
    cpu_read("t1_rd0", 4'd0, 1'b1);
    cpu_read("t1_rd1", 4'd1, 1'b1);
    cpu_read("t1_rd2", 4'd2, 1'b1);
    check_val("t1_const0", model_mem[0], 8'h1E);

    // Test 2: 17 bytes without last -> overflow
    start_load();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    check_val("ovf_err", bus.o_ld_err, 1);
    check_val("ovf_state", o_state, ST_RELEASE);
    check_val("ovf_addr", bus.o_ld_addr, 0);
    bus.i_ld_valid = 1'b1;
    bus.i_ld_data  = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      check_val("ovf_ready_low", bus.o_ld_ready, 0);
      tick();
    end
    bus.i_ld_valid = 1'b0;
    check_val("ovf_err_sticky", bus.o_ld_err, 1);
    release_cpu();
    for (int i = 0; i < 16; i++) cpu_read("ovf_rd", AW'(i), 1'b1);

    // Test 3: CPU write/read, write gated by i_clke
    cpu_write(4'd7, 8'h55, 1'b1);
    cpu_read("wr_rd7", 4'd7, 1'b1);
    check_val("wr_const7", model_mem[7], 8'h55);
    cpu_write(4'd7, 8'h99, 1'b0);
    cpu_read("wr_noclke_rd7", 4'd7, 1'b1);
    bus.i_addr = 4'd7;
    #1;
    check_val("odata_re_low", bus.o_data, 0);

    // Test 4: reset after 2 bytes of a 5-byte load
    cpu_write(4'd2, 8'h77, 1'b1);
    start_load();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_val("mid_rst_state", o_state, ST_RUN);
    check_val("mid_rst_cpu_reset", o_cpu_reset, 0);
    check_val("mid_rst_ready", bus.o_ld_ready, 0);
    cpu_read("mid_rst_rd0", 4'd0, 1'b1);
    cpu_read("mid_rst_rd1", 4'd1, 1'b1);
    cpu_read("mid_rst_rd2", 4'd2, 1'b1);

    // Test 5: preload address 9, then load 2 bytes
    cpu_write(4'd9, 8'hAA, 1'b1);
    start_load();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    release_cpu();
    cpu_read("clr_rd9", 4'd9, 1'b1);
    cpu_read("clr_rd0", 4'd0, 1'b1);
    cpu_read("clr_rd1", 4'd1, 1'b1);
    bus.i_addr = 4'd9;
    bus.i_re   = 1'b1;
    #1;
`ifdef MEM_CLEAR_EN
    check_val("clr_addr9_const", bus.o_data, 8'h00);
`else
    check_val("clr_addr9_const", bus.o_data, 8'hAA);
`endif
    bus.i_re = 1'b0;

    check_val("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
